// File: rtl/iddmm_pkg.sv
// Shared definitions for the word-serial Montgomery multiplier.
//   DefaultK / DefaultN : default word width and words per operand
//   state_t / St*       : FSM state encoding used by iddmm_word_serial
package iddmm_pkg;

    localparam int unsigned DefaultK = 256;
    localparam int unsigned DefaultN = 16;

    typedef logic [3:0] state_t;

    localparam state_t StIdle  = 4'd0;
    localparam state_t StLoad  = 4'd1;
    localparam state_t StMul   = 4'd2;
    localparam state_t StTop   = 4'd3;
    localparam state_t StQcalc = 4'd4;
    localparam state_t StRed   = 4'd5;
    localparam state_t StShift = 4'd6;
    localparam state_t StSub   = 4'd7;
    localparam state_t StOut   = 4'd8;

endpackage

// File: rtl/iddmm_word_serial_if.sv
// Operand load stream and result stream of iddmm_word_serial.
//   s_valid/s_ready/s_data        : load stream, x then y then p, LSW first
//   m_valid/m_ready/m_data/m_last : result stream, LSW first, m_last on last word
//   master : the side that feeds operands and drains results
//   slave  : the multiplier
interface iddmm_word_serial_if import iddmm_pkg::*; #(
    parameter int unsigned K = DefaultK
) ();

    logic         s_valid;
    logic         s_ready;
    logic [K-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [K-1:0] m_data;
    logic         m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

endinterface

// File: rtl/iddmm_mac.sv
// Combinational multiply-accumulate: res = a + b*c + d.
//   a, b, c, d : K-bit operands
//   res        : full 2K-bit result; the maximum (2^K-1) + (2^K-1)^2 + (2^K-1)
//                equals 2^(2K)-1, so nothing is lost.
module iddmm_mac import iddmm_pkg::*; #(
    parameter int unsigned K = DefaultK
) (
    input  logic [K-1:0]   a,
    input  logic [K-1:0]   b,
    input  logic [K-1:0]   c,
    input  logic [K-1:0]   d,
    output logic [2*K-1:0] res
);

    always_comb begin
        res = (2*K)'(a) + (2*K)'(b) * (2*K)'(c) + (2*K)'(d);
    end

endmodule

// File: rtl/iddmm_word_serial.sv
// Word-serial CIOS Montgomery multiplier: result = x*y*2^(-N*K) mod p.
//   clk, rst  : clock, synchronous active-high reset
//   mprime    : -p^-1 mod 2^K, captured with the first load beat
//   bus       : load stream (3N words: x, y, p) and result stream (N words)
//   busy      : high whenever the FSM is not idle
//   sub_done  : final subtraction of p was applied to the presented result
module iddmm_word_serial import iddmm_pkg::*; #(
    parameter int unsigned K      = DefaultK,
    parameter int unsigned N      = DefaultN,
    parameter int unsigned ADDR_W = $clog2(N) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [K-1:0]          mprime,
    iddmm_word_serial_if.slave    bus,
    output logic                  busy,
    output logic                  sub_done
);

    localparam int unsigned       IdxW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N - 1);
    localparam logic [IdxW-1:0]   TopIdx  = IdxW'(N - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] j_q, j_d;        // word index within a phase
    logic [ADDR_W-1:0] i_q, i_d;        // outer iteration index
    logic [1:0]        sel_q, sel_d;    // load target: 0 x, 1 y, 2 p
    logic [K-1:0]      c_q, c_d;        // carry word
    logic [K-1:0]      q_q, q_d;
    logic [K-1:0]      mp_q, mp_d;
    logic [K-1:0]      x_q [N];
    logic [K-1:0]      x_d [N];
    logic [K-1:0]      y_q [N];
    logic [K-1:0]      y_d [N];
    logic [K-1:0]      p_q [N];
    logic [K-1:0]      p_d [N];
    // Accumulator a[0..N-1] lives in a_q; a[N] and a[N+1] are kept separately.
    logic [K-1:0]      a_q [N];
    logic [K-1:0]      a_d [N];
    logic [K-1:0]      an_q, an_d;
    logic [K-1:0]      an1_q, an1_d;
    logic [K-1:0]      res_q [N];       // a - p, word by word
    logic [K-1:0]      res_d [N];
    logic              bw_q, bw_d;      // borrow chain of the final subtraction
    logic              sub_q, sub_d;

    logic [IdxW-1:0]   j_idx, j_prev, i_idx;
    logic              j_last, i_last;
    logic [K-1:0]      mac_a, mac_b, mac_c, mac_d;
    logic [2*K-1:0]    mac_res;
    logic [K-1:0]      mac_lo, mac_hi;
    logic [K:0]        diff;
    logic              out_valid;

    assign j_idx  = j_q[IdxW-1:0];
    assign j_prev = j_idx - IdxW'(1);
    assign i_idx  = i_q[IdxW-1:0];
    assign j_last = (j_q == LastIdx);
    assign i_last = (i_q == LastIdx);
    assign mac_lo = mac_res[K-1:0];
    assign mac_hi = mac_res[2*K-1:K];
    assign diff   = {1'b0, a_q[j_idx]} - {1'b0, p_q[j_idx]} - {{K{1'b0}}, bw_q};

    // TOP and SHIFT reuse the MAC as a plain adder: a[N] + C.
    always_comb begin
        mac_a = an_q;
        mac_b = '0;
        mac_c = '0;
        mac_d = c_q;
        case (state_q)
            StMul: begin
                mac_a = a_q[j_idx];
                mac_b = x_q[j_idx];
                mac_c = y_q[i_idx];
                mac_d = c_q;
            end
            StQcalc: begin
                mac_a = '0;
                mac_b = a_q[0];
                mac_c = mp_q;
                mac_d = '0;
            end
            StRed: begin
                mac_a = a_q[j_idx];
                mac_b = q_q;
                mac_c = p_q[j_idx];
                mac_d = c_q;
            end
            default: ;
        endcase
    end

    iddmm_mac #(
        .K (K)
    ) u_mac (
        .a   (mac_a),
        .b   (mac_b),
        .c   (mac_c),
        .d   (mac_d),
        .res (mac_res)
    );

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        i_d     = i_q;
        sel_d   = sel_q;
        c_d     = c_q;
        q_d     = q_q;
        mp_d    = mp_q;
        x_d     = x_q;
        y_d     = y_q;
        p_d     = p_q;
        a_d     = a_q;
        an_d    = an_q;
        an1_d   = an1_q;
        res_d   = res_q;
        bw_d    = bw_q;
        sub_d   = sub_q;
        case (state_q)
            StIdle, StLoad: begin
                if (bus.s_valid) begin
                    if (state_q == StIdle) begin
                        for (int w = 0; w < N; w++) begin
                            a_d[w] = '0;
                        end
                        an_d    = '0;
                        an1_d   = '0;
                        mp_d    = mprime;
                        state_d = StLoad;
                    end
                    case (sel_q)
                        2'd0:    x_d[j_idx] = bus.s_data;
                        2'd1:    y_d[j_idx] = bus.s_data;
                        default: p_d[j_idx] = bus.s_data;
                    endcase
                    if (j_last) begin
                        j_d = '0;
                        if (sel_q == 2'd2) begin
                            sel_d   = 2'd0;
                            i_d     = '0;
                            c_d     = '0;
                            state_d = StMul;
                        end else begin
                            sel_d = sel_q + 2'd1;
                        end
                    end else begin
                        j_d = j_q + ADDR_W'(1);
                    end
                end
            end
            StMul: begin
                a_d[j_idx] = mac_lo;
                c_d        = mac_hi;
                if (j_last) begin
                    j_d     = '0;
                    state_d = StTop;
                end else begin
                    j_d = j_q + ADDR_W'(1);
                end
            end
            StTop: begin
                an_d    = mac_lo;
                an1_d   = mac_hi;
                state_d = StQcalc;
            end
            StQcalc: begin
                q_d     = mac_lo;
                c_d     = '0;
                state_d = StRed;
            end
            StRed: begin
                // Word 0 of a + q*p is zero by construction of q; the rest shift down.
                if (j_q != '0) begin
                    a_d[j_prev] = mac_lo;
                end
                c_d = mac_hi;
                if (j_last) begin
                    j_d     = '0;
                    state_d = StShift;
                end else begin
                    j_d = j_q + ADDR_W'(1);
                end
            end
            StShift: begin
                a_d[TopIdx] = mac_lo;
                an_d        = an1_q + mac_hi;
                if (i_last) begin
                    i_d     = '0;
                    bw_d    = 1'b0;
                    state_d = StSub;
                end else begin
                    i_d     = i_q + ADDR_W'(1);
                    c_d     = '0;
                    state_d = StMul;
                end
            end
            StSub: begin
                res_d[j_idx] = diff[K-1:0];
                bw_d         = diff[K];
                if (j_last) begin
                    // a >= p if it overflowed into a[N] or the borrow chain closed clean.
                    sub_d   = (an_q != '0) || !diff[K];
                    j_d     = '0;
                    state_d = StOut;
                end else begin
                    j_d = j_q + ADDR_W'(1);
                end
            end
            StOut: begin
                if (bus.m_ready) begin
                    if (j_last) begin
                        j_d     = '0;
                        state_d = StIdle;
                    end else begin
                        j_d = j_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            j_q     <= '0;
            i_q     <= '0;
            sel_q   <= '0;
            c_q     <= '0;
            q_q     <= '0;
            mp_q    <= '0;
            an_q    <= '0;
            an1_q   <= '0;
            bw_q    <= 1'b0;
            sub_q   <= 1'b0;
            for (int w = 0; w < N; w++) begin
                x_q[w]   <= '0;
                y_q[w]   <= '0;
                p_q[w]   <= '0;
                a_q[w]   <= '0;
                res_q[w] <= '0;
            end
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            i_q     <= i_d;
            sel_q   <= sel_d;
            c_q     <= c_d;
            q_q     <= q_d;
            mp_q    <= mp_d;
            an_q    <= an_d;
            an1_q   <= an1_d;
            bw_q    <= bw_d;
            sub_q   <= sub_d;
            x_q     <= x_d;
            y_q     <= y_d;
            p_q     <= p_d;
            a_q     <= a_d;
            res_q   <= res_d;
        end
    end

    // Outputs are forced quiet while rst is held, independent of register contents.
    assign out_valid   = !rst && (state_q == StOut);
    assign bus.s_ready = !rst && ((state_q == StIdle) || (state_q == StLoad));
    assign bus.m_valid = out_valid;
    assign bus.m_data  = out_valid ? (sub_q ? res_q[j_idx] : a_q[j_idx]) : '0;
    assign bus.m_last  = out_valid && j_last;
    assign busy        = !rst && (state_q != StIdle);
    assign sub_done    = !rst && sub_q;

endmodule

// File: tb/tb_iddmm_word_serial.sv
// Directed bench for iddmm_word_serial with K=8, N=2, p=0xFFF1, mprime=0xEF.
module tb_iddmm_word_serial;

    localparam int unsigned K = 8;
    localparam int unsigned N = 2;

    logic         clk;
    logic         rst;
    logic [K-1:0] mprime;
    logic         busy;
    logic         sub_done;
    int           n_tests;
    int           n_fail;

    iddmm_word_serial_if #(.K(K)) bus ();

    iddmm_word_serial #(
        .K (K),
        .N (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mprime   (mprime),
        .bus      (bus),
        .busy     (busy),
        .sub_done (sub_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Six beats: x LSW, x MSW, y LSW, y MSW, p LSW, p MSW. Ends just after the
    // edge that accepts the last beat; s_valid is left as driven.
    task automatic load_op(input logic [15:0] x, input logic [15:0] y);
        logic [7:0] beats [6];
        int         spin;
        beats = '{x[7:0], x[15:8], y[7:0], y[15:8], 8'hF1, 8'hFF};
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = beats[b];
            spin = 0;
            while (!bus.s_ready && spin < 50) begin
                @(negedge clk);
                spin++;
            end
            check("load_ready", {31'd0, bus.s_ready}, 32'd1);
            @(posedge clk);
        end
    endtask

    // Entered just after the last load beat edge. hold keeps s_valid high with
    // junk data through compute. Ends just after the m_last handshake edge.
    task automatic collect(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic exp_sub, input int stall, input logic hold);
        int lat;
        int spin;
        int ready_seen;
        lat        = 0;
        ready_seen = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.s_valid = hold;
            bus.s_data  = 8'hAA;
            if (bus.s_ready) ready_seen++;
        end while (!bus.m_valid && lat < 400);
        check({tag, "_valid0"}, {31'd0, bus.m_valid}, 32'd1);
        check({tag, "_latency"}, lat, 32'd17);
        check({tag, "_no_ready_in_compute"}, ready_seen, 32'd0);
        check({tag, "_sub_done"}, {31'd0, sub_done}, {31'd0, exp_sub});
        if (stall > 0) begin
            bus.m_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check({tag, "_stall_valid"}, {31'd0, bus.m_valid}, 32'd1);
                check({tag, "_stall_data"}, {24'd0, bus.m_data}, {24'd0, e0});
                check({tag, "_stall_last"}, {31'd0, bus.m_last}, 32'd0);
            end
            bus.m_ready = 1'b1;
        end
        check({tag, "_data0"}, {24'd0, bus.m_data}, {24'd0, e0});
        check({tag, "_last0"}, {31'd0, bus.m_last}, 32'd0);
        @(posedge clk);
        spin = 0;
        do begin
            @(negedge clk);
            spin++;
        end while (!bus.m_valid && spin < 50);
        check({tag, "_valid1"}, {31'd0, bus.m_valid}, 32'd1);
        check({tag, "_data1"}, {24'd0, bus.m_data}, {24'd0, e1});
        check({tag, "_last1"}, {31'd0, bus.m_last}, 32'd1);
        @(posedge clk);
    endtask

    initial begin
        int vcount;
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        mprime      = 8'hEF;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("rst_m_data", {24'd0, bus.m_data}, 32'd0);
        check("rst_m_last", {31'd0, bus.m_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sub_done", {31'd0, sub_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // 1 * 0xE1 * R^-1 = 0x000F, no subtraction
        load_op(16'h0001, 16'h00E1);
        collect("x1", 8'h0F, 8'h00, 1'b0, 0, 1'b0);

        // (p-1)^2 * R^-1 = R^-1 = 0xEEE1, a[N] set so p is subtracted
        load_op(16'hFFF0, 16'hFFF0);
        collect("xm1", 8'hE1, 8'hEE, 1'b1, 0, 1'b0);

        load_op(16'h0000, 16'h1234);
        collect("zero", 8'h00, 8'h00, 1'b0, 0, 1'b0);

        // 2 * 0xE1 * R^-1 = 0x001E, first word stalled 3 cycles
        load_op(16'h0002, 16'h00E1);
        collect("stall", 8'h1E, 8'h00, 1'b0, 3, 1'b0);

        // Reset in cycle 5 after the last beat: i=0, first RED cycle.
        load_op(16'h0001, 16'h00E1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("midrst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_release_ready", {31'd0, bus.s_ready}, 32'd1);
        check("midrst_release_busy", {31'd0, busy}, 32'd0);
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.m_valid) vcount++;
        end
        check("midrst_no_m_valid", vcount, 32'd0);
        load_op(16'h000F, 16'h000F);
        collect("after_rst", 8'h0F, 8'h00, 1'b0, 0, 1'b0);

        // s_valid held high during compute, then a back-to-back transaction.
        load_op(16'hFFF0, 16'hFFF0);
        collect("hold", 8'hE1, 8'hEE, 1'b1, 0, 1'b1);
        load_op(16'h0001, 16'h00E1);
        collect("b2b", 8'h0F, 8'h00, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iddmm_word_serial.md
IDDMM_WORD_SERIAL -- requirements
Module: iddmm_word_serial

Interface
REQ-001 SHALL have parameter K, default 256, meaning word width in bits.
REQ-002 SHALL have parameter N, default 16, meaning words per operand; the operand width is N*K.
REQ-003 SHALL have parameter ADDR_W, default $clog2(N)+1, meaning the word-index width.
REQ-004 SHALL have port clk, input, 1 bit, the only clock.
REQ-005 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-006 SHALL have port mprime, input, K bits, holding -p^-1 mod 2^K; it is sampled on the first accepted load beat.
REQ-007 SHALL have s_valid, input, 1 bit; s_ready, output, 1 bit; and s_data, input, K bits, forming the operand load stream.
REQ-008 SHALL have m_valid, output, 1 bit; m_ready, input, 1 bit; m_data, output, K bits; and m_last, output, 1 bit, forming the result stream.
REQ-009 SHALL have busy, output, 1 bit, high whenever the state is not IDLE.
REQ-010 SHALL have sub_done, output, 1 bit, meaning the final subtraction of p was applied; it is valid while m_valid is high.

Function
REQ-011 SHALL compute x*y*2^(-N*K) mod p, given odd p and x, y < p.
REQ-012 SHALL use the states IDLE, LOAD, MUL, TOP, QCALC, RED, SHIFT, SUB and OUT.
REQ-013 SHALL drive s_ready high only in IDLE and LOAD; an IDLE beat enters LOAD.
REQ-014 SHALL accept exactly 3N load beats, least-significant word first, in the order x[0..N-1], y[0..N-1], p[0..N-1].
REQ-015 SHALL clear the accumulator a[0..N+1] on the first load beat.
REQ-016 SHALL, in MUL (N cycles, j=0..N-1, outer index i), compute t = a[j] + x[j]*y[i] + C, then set a[j] = t[K-1:0] and C = t[2K-1:K]; C is cleared at MUL entry.
REQ-017 SHALL, in TOP (1 cycle), compute {a[N+1], a[N]} = a[N] + C.
REQ-018 SHALL, in QCALC (1 cycle), compute q = (a[0]*mprime) mod 2^K.
REQ-019 SHALL, in RED (N cycles), compute t = a[j] + q*p[j] + C, write t-low to a[j-1] for j>0, discard it for j=0, and set C = t-high; C is cleared at RED entry.
REQ-020 SHALL, in SHIFT (1 cycle), set a[N-1] = low(a[N] + C) and a[N] = a[N+1] + carry(a[N] + C); then i increments, returning to MUL if i < N, else going to SUB.
REQ-021 SHALL make each outer iteration 2N+3 cycles, for a total compute time of N(2N+3) cycles.
REQ-022 SHALL, in SUB (N cycles), form d = a - p word-serially with a borrow chain into a result buffer.
REQ-023 SHALL select d when a[N] = 1 or the final borrow is 0, and select a otherwise; the choice is latched into sub_done.
REQ-024 SHALL, in OUT, present N selected words in LSW-first order, with m_last on word N-1; a word advances only on m_valid && m_ready.
REQ-025 SHALL hold m_data, m_last and m_valid stable while m_ready is low.
REQ-026 SHALL raise the first m_valid exactly N(2N+3)+N+1 cycles after the cycle in which the last load beat is accepted.
REQ-027 SHALL return to IDLE after the m_last handshake; a back-to-back load is accepted on the following cycle.
REQ-028 SHALL ignore s_valid while not in IDLE or LOAD; no data is consumed in those states.
REQ-029 SHALL treat a word-index counter reaching N-1 as the phase terminator; counters never wrap mid-phase.
REQ-030 SHALL use a full 2K-bit MAC result; no truncation occurs before the carry split.

Reset
REQ-031 SHALL, while rst is high at a clock edge, force state IDLE and clear all counters, C, q, a[] and the result buffer.
REQ-032 SHALL drive the following values under reset: s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0 and sub_done=0.
REQ-033 SHALL drive s_ready=1 on the first cycle after reset is released.
REQ-034 SHALL, on reset asserted mid-LOAD, mid-compute or mid-OUT, abandon the transaction with no further m_valid; the next load starts clean.

Structure
REQ-035 SHALL take the state enum and default K/N values from the shared package iddmm_pkg.
REQ-036 SHALL contain one sub-module, iddmm_mac, which computes a + b*c + d with K-bit inputs and a 2K-bit combinational output; it is shared by MUL, RED and QCALC.
REQ-037 SHALL hold x, y and p in internal register arrays, N words each.

Verification (K=8, N=2, p=0xFFF1, mprime=0xEF)
REQ-038 SHALL be verified with x=0x0001, y=0x00E1: the result words SHALL be 0x0F then 0x00, with sub_done per the model and first m_valid 17 cycles after the last load beat.
REQ-039 SHALL be verified with x=y=0xFFF0: the result words SHALL be 0xE1 then 0xEE (0xEEE1 = R^-1 mod p).
REQ-040 SHALL be verified with x=0x0000, y=0x1234: the result words SHALL be 0x00, 0x00, with m_last on the second word.
REQ-041 SHALL be verified with m_ready held low 3 cycles on the first result word: m_data SHALL stay stable, and both words SHALL be delivered in order.
REQ-042 SHALL be verified with rst pulsed during RED: busy SHALL drop next cycle and no m_valid SHALL appear; a following load with x=0x000F, y=0x000F SHALL return 0x0F, 0x00.
REQ-043 SHALL be verified with s_valid held high throughout compute: no extra beats SHALL be consumed, and a second transaction back-to-back SHALL give a correct result.
